// File: rtl/axil_pkg.sv
// axil_pkg
//   Shared definitions for the AXI-Lite N-way address-decoding bus:
//   response codes, write/read FSM state encodings, the status counter
//   width and a saturating counter helper.
package axil_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;
  localparam int unsigned RESP_DECERR = 3;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FWD  = 2'd1,
    W_RESP = 2'd2,
    W_ERR  = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FWD  = 2'd1,
    R_DATA = 2'd2,
    R_ERR  = 2'd3
  } rd_state_t;

  // Adds 0..3 to a counter and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// axil_addr_decode
//   Combinational region decoder: the port index is the address shifted
//   right by REGION_SHIFT; any region at or beyond N_PORTS is a decode error.
//   Ports:
//     addr - address to decode
//     idx  - selected downstream port (meaningful only when err is low)
//     err  - region does not map to any downstream port
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int N_PORTS      = 2,
  parameter int REGION_SHIFT = 4,
  parameter int IDX_W        = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] region;

  assign region = addr >> REGION_SHIFT;
  assign err    = (region >= ADDR_WIDTH'(N_PORTS));
  assign idx    = region[IDX_W-1:0];

endmodule

// File: rtl/axil_bus_nway.sv
// axil_bus_nway
//   AXI-Lite 1-to-N address-decoding bus. One upstream slave port (s0_axi_*)
//   is routed to one of N_PORTS downstream master ports (m_axi_*, flattened,
//   port i in slice i) selected by addr >> REGION_SHIFT. Independent write
//   and read FSMs, one outstanding transaction each. Unmapped regions are
//   answered locally with DECERR.
//   Ports:
//     s0_axi_aclk / s0_axi_aresetn - clock, async active-low reset
//     s0_axi_aw*/w*/b*/ar*/r*       - upstream AXI-Lite slave channels
//     m_axi_aw*/w*/b*/ar*/r*        - downstream AXI-Lite master channels
//     wr_count/rd_count/err_count   - saturating completion/error counters
module axil_bus_nway
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RESP_WIDTH   = 3,
  parameter int N_PORTS      = 2,
  parameter int REGION_SHIFT = 4
) (
  input  logic                             s0_axi_aclk,
  input  logic                             s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,
  output logic [N_PORTS*ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [N_PORTS-1:0]               m_axi_awvalid,
  input  logic [N_PORTS-1:0]               m_axi_awready,
  output logic [N_PORTS*DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [N_PORTS*DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic [N_PORTS-1:0]               m_axi_wvalid,
  input  logic [N_PORTS-1:0]               m_axi_wready,
  input  logic [N_PORTS*RESP_WIDTH-1:0]    m_axi_bresp,
  input  logic [N_PORTS-1:0]               m_axi_bvalid,
  output logic [N_PORTS-1:0]               m_axi_bready,
  output logic [N_PORTS*ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [N_PORTS-1:0]               m_axi_arvalid,
  input  logic [N_PORTS-1:0]               m_axi_arready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [N_PORTS*RESP_WIDTH-1:0]    m_axi_rresp,
  input  logic [N_PORTS-1:0]               m_axi_rvalid,
  output logic [N_PORTS-1:0]               m_axi_rready,
  output logic [15:0]                      wr_count,
  output logic [15:0]                      rd_count,
  output logic [15:0]                      err_count
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // ---------------- write path state ----------------
  wr_state_t               w_state, w_state_n;
  logic                    aw_held, aw_held_n, w_held, w_held_n;
  logic                    aw_pend, aw_pend_n, w_pend, w_pend_n;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_n;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_n;
  logic [STRB_W-1:0]       w_strb_q, w_strb_n;
  logic [IDX_W-1:0]        w_idx_q, w_idx_n;
  logic                    bvalid_q, bvalid_n;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_n;

  // ---------------- read path state ----------------
  rd_state_t               r_state, r_state_n;
  logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_n;
  logic [IDX_W-1:0]        r_idx_q, r_idx_n;
  logic                    rvalid_q, rvalid_n;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_n;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   wdec_addr;
  logic [IDX_W-1:0]        wdec_idx, rdec_idx;
  logic                    wdec_err, rdec_err;
  logic [N_PORTS-1:0]      w_sel, r_sel;
  logic                    wr_done, rd_done;
  logic [1:0]              err_inc;

  // Decode at capture time so the downstream valid can rise on the very
  // next cycle; if AW arrived earlier its address is already registered.
  assign wdec_addr = aw_held ? aw_addr_q : s0_axi_awaddr;

  axil_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_PORTS     (N_PORTS),
    .REGION_SHIFT(REGION_SHIFT),
    .IDX_W       (IDX_W)
  ) u_wdec (
    .addr(wdec_addr),
    .idx (wdec_idx),
    .err (wdec_err)
  );

  axil_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_PORTS     (N_PORTS),
    .REGION_SHIFT(REGION_SHIFT),
    .IDX_W       (IDX_W)
  ) u_rdec (
    .addr(s0_axi_araddr),
    .idx (rdec_idx),
    .err (rdec_err)
  );

  // Upstream readies are gated by reset so nothing is accepted while held
  // in reset, yet they are high on the first cycle after release.
  assign s0_axi_awready = s0_axi_aresetn && (w_state == W_IDLE) && !aw_held;
  assign s0_axi_wready  = s0_axi_aresetn && (w_state == W_IDLE) && !w_held;
  assign s0_axi_arready = s0_axi_aresetn && (r_state == R_IDLE);

  assign aw_hs = s0_axi_awvalid && s0_axi_awready;
  assign w_hs  = s0_axi_wvalid && s0_axi_wready;
  assign ar_hs = s0_axi_arvalid && s0_axi_arready;

  assign s0_axi_bvalid = bvalid_q;
  assign s0_axi_bresp  = bresp_q;
  assign s0_axi_rvalid = rvalid_q;
  assign s0_axi_rresp  = rresp_q;
  assign s0_axi_rdata  = rdata_q;

  // Address/data/strobe are broadcast; only the selected port gets handshakes.
  assign w_sel = N_PORTS'(1) << w_idx_q;
  assign r_sel = N_PORTS'(1) << r_idx_q;

  assign m_axi_awaddr  = {N_PORTS{aw_addr_q}};
  assign m_axi_wdata   = {N_PORTS{w_data_q}};
  assign m_axi_wstrb   = {N_PORTS{w_strb_q}};
  assign m_axi_araddr  = {N_PORTS{ar_addr_q}};

  assign m_axi_awvalid = (w_state == W_FWD && aw_pend) ? w_sel : '0;
  assign m_axi_wvalid  = (w_state == W_FWD && w_pend) ? w_sel : '0;
  assign m_axi_bready  = (w_state == W_RESP && !bvalid_q) ? w_sel : '0;
  assign m_axi_arvalid = (r_state == R_FWD) ? r_sel : '0;
  assign m_axi_rready  = (r_state == R_DATA && !rvalid_q) ? r_sel : '0;

  // Write FSM next-state
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_pend_n = aw_pend;
    w_pend_n  = w_pend;
    aw_addr_n = aw_addr_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    w_idx_n   = w_idx_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_n = 1'b1;
          aw_addr_n = s0_axi_awaddr;
        end
        if (w_hs) begin
          w_held_n = 1'b1;
          w_data_n = s0_axi_wdata;
          w_strb_n = s0_axi_wstrb;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_idx_n   = wdec_idx;
          if (wdec_err) begin
            w_state_n = W_ERR;
            bvalid_n  = 1'b1;
            bresp_n   = RESP_WIDTH'(RESP_DECERR);
          end else begin
            w_state_n = W_FWD;
            aw_pend_n = 1'b1;
            w_pend_n  = 1'b1;
          end
        end
      end
      W_FWD: begin
        if (aw_pend && m_axi_awready[w_idx_q]) aw_pend_n = 1'b0;
        if (w_pend && m_axi_wready[w_idx_q]) w_pend_n = 1'b0;
        if (!aw_pend_n && !w_pend_n) w_state_n = W_RESP;
      end
      W_RESP: begin
        if (!bvalid_q) begin
          if (m_axi_bvalid[w_idx_q]) begin
            bvalid_n = 1'b1;
            bresp_n  = m_axi_bresp[w_idx_q*RESP_WIDTH +: RESP_WIDTH];
          end
        end else if (s0_axi_bready) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      W_ERR: begin
        if (s0_axi_bready) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_idx_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state   <= w_state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      aw_pend   <= aw_pend_n;
      w_pend    <= w_pend_n;
      aw_addr_q <= aw_addr_n;
      w_data_q  <= w_data_n;
      w_strb_q  <= w_strb_n;
      w_idx_q   <= w_idx_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
    end
  end

  // Read FSM next-state
  always_comb begin
    r_state_n = r_state;
    ar_addr_n = ar_addr_q;
    r_idx_n   = r_idx_q;
    rvalid_n  = rvalid_q;
    rresp_n   = rresp_q;
    rdata_n   = rdata_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          ar_addr_n = s0_axi_araddr;
          r_idx_n   = rdec_idx;
          if (rdec_err) begin
            r_state_n = R_ERR;
            rvalid_n  = 1'b1;
            rresp_n   = RESP_WIDTH'(RESP_DECERR);
            rdata_n   = '0;
          end else begin
            r_state_n = R_FWD;
          end
        end
      end
      R_FWD: begin
        if (m_axi_arready[r_idx_q]) r_state_n = R_DATA;
      end
      R_DATA: begin
        if (!rvalid_q) begin
          if (m_axi_rvalid[r_idx_q]) begin
            rvalid_n = 1'b1;
            rdata_n  = m_axi_rdata[r_idx_q*DATA_WIDTH +: DATA_WIDTH];
            rresp_n  = m_axi_rresp[r_idx_q*RESP_WIDTH +: RESP_WIDTH];
          end
        end else if (s0_axi_rready) begin
          rvalid_n  = 1'b0;
          r_state_n = R_IDLE;
        end
      end
      R_ERR: begin
        if (s0_axi_rready) begin
          rvalid_n  = 1'b0;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      r_idx_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state   <= r_state_n;
      ar_addr_q <= ar_addr_n;
      r_idx_q   <= r_idx_n;
      rvalid_q  <= rvalid_n;
      rresp_q   <= rresp_n;
      rdata_q   <= rdata_n;
    end
  end

  // Completion counters; a simultaneous write and read error add two.
  assign wr_done = bvalid_q && s0_axi_bready;
  assign rd_done = rvalid_q && s0_axi_rready;
  assign err_inc = {1'b0, wr_done && (bresp_q != '0)}
                 + {1'b0, rd_done && (rresp_q != '0)};

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      wr_count  <= sat_add(wr_count, {1'b0, wr_done});
      rd_count  <= sat_add(rd_count, {1'b0, rd_done});
      err_count <= sat_add(err_count, err_inc);
    end
  end

endmodule

// File: tb/tb_axil_bus_nway.sv
// tb_axil_bus_nway
//   Directed bench for axil_bus_nway (N_PORTS=2, REGION_SHIFT=4). Expected
//   responses are queued when a transaction is issued and compared when the
//   upstream response channel fires.
module tb_axil_bus_nway;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RW = 3;

  logic              clk, rst_n;
  logic [AW-1:0]     s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [DW/8-1:0]   s_wstrb;
  logic [RW-1:0]     s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0]   m_awaddr, m_araddr;
  logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*DW-1:0]   m_wdata, m_rdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*RW-1:0]   m_bresp, m_rresp;
  logic [15:0]       wr_count, rd_count, err_count;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
  } rexp_t;

  logic [RW-1:0] exp_b_q[$];
  rexp_t         exp_r_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  axil_bus_nway #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .N_PORTS(N), .REGION_SHIFT(4)
  ) dut (
    .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
    .s0_axi_awaddr(s_awaddr), .s0_axi_awvalid(s_awvalid), .s0_axi_awready(s_awready),
    .s0_axi_wdata(s_wdata), .s0_axi_wstrb(s_wstrb), .s0_axi_wvalid(s_wvalid),
    .s0_axi_wready(s_wready), .s0_axi_bresp(s_bresp), .s0_axi_bvalid(s_bvalid),
    .s0_axi_bready(s_bready), .s0_axi_araddr(s_araddr), .s0_axi_arvalid(s_arvalid),
    .s0_axi_arready(s_arready), .s0_axi_rdata(s_rdata), .s0_axi_rresp(s_rresp),
    .s0_axi_rvalid(s_rvalid), .s0_axi_rready(s_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid),
    .m_axi_wready(m_wready), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready), .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
    m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic expect_b(input string tag);
    logic [RW-1:0] e;
    for (int i = 0; i < 20 && !s_bvalid; i++) tick();
    check({tag, "_bvalid"}, s_bvalid, 1);
    check({tag, "_sb_b"}, exp_b_q.size() > 0, 1);
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      check({tag, "_bresp"}, s_bresp, e);
    end
  endtask

  task automatic expect_r(input string tag);
    rexp_t e;
    for (int i = 0; i < 20 && !s_rvalid; i++) tick();
    check({tag, "_rvalid"}, s_rvalid, 1);
    check({tag, "_sb_r"}, exp_r_q.size() > 0, 1);
    if (exp_r_q.size() > 0) begin
      e = exp_r_q.pop_front();
      check({tag, "_rresp"}, s_rresp, e.resp);
      check({tag, "_rdata"}, s_rdata, e.data);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    tick();
    // reset state
    check("rst_awready", s_awready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_m_awvalid", m_awvalid, 0);
    rst_n = 1;
    #1;
    check("rel_awready", s_awready, 1);
    check("rel_wready", s_wready, 1);
    check("rel_arready", s_arready, 1);

    // write to port 0, AW and W together
    s_awaddr = 8'h00; s_awvalid = 1; s_wdata = 32'd56; s_wstrb = 4'hF; s_wvalid = 1;
    s_bready = 1; m_awready = 2'b01; m_wready = 2'b01;
    exp_b_q.push_back(3'd0);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    check("p0_awvalid", m_awvalid, 2'b01);
    check("p0_wvalid", m_wvalid, 2'b01);
    check("p0_awaddr", m_awaddr[7:0], 8'h00);
    check("p0_wdata", m_wdata[31:0], 32'd56);
    check("p0_wstrb", m_wstrb[3:0], 4'hF);
    tick();
    check("p0_valid_drop", {m_awvalid, m_wvalid}, 4'b0000);
    check("p0_bready", m_bready, 2'b01);
    m_bvalid = 2'b01; m_bresp = '0;
    tick();
    m_bvalid = 0; m_awready = 0; m_wready = 0;
    expect_b("p0");
    tick();
    check("p0_wr_count", wr_count, 1);
    check("p0_bvalid_clr", s_bvalid, 0);

    // write to port 1, AW first, W three cycles later, AW backpressured
    do_reset();
    s_awaddr = 8'h10; s_awvalid = 1; s_bready = 1; m_wready = 2'b10;
    exp_b_q.push_back(3'd0);
    tick();
    s_awvalid = 0;
    check("p1_aw_only_awready", s_awready, 0);
    check("p1_aw_only_wready", s_wready, 1);
    check("p1_aw_only_awvalid", m_awvalid, 0);
    tick();
    tick();
    s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    check("p1_awvalid", m_awvalid, 2'b10);
    check("p1_wvalid", m_wvalid, 2'b10);
    check("p1_awaddr", m_awaddr[15:8], 8'h10);
    check("p1_wdata", m_wdata[63:32], 32'hA5A5A5A5);
    tick();
    check("p1_aw_held1", m_awvalid, 2'b10);
    check("p1_w_dropped", m_wvalid, 2'b00);
    tick();
    check("p1_aw_held2", m_awvalid, 2'b10);
    m_awready = 2'b10;
    tick();
    m_awready = 0;
    check("p1_aw_dropped", m_awvalid, 2'b00);
    check("p1_bready", m_bready, 2'b10);
    m_bvalid = 2'b10; m_bresp = '0;
    tick();
    m_bvalid = 0;
    expect_b("p1");
    tick();
    check("p1_wr_count", wr_count, 1);

    // decode errors on both channels at once
    do_reset();
    s_awaddr = 8'h20; s_awvalid = 1; s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1;
    s_araddr = 8'h30; s_arvalid = 1; s_bready = 1; s_rready = 1;
    m_awready = '1; m_wready = '1; m_arready = '1;
    exp_b_q.push_back(3'd3);
    exp_r_q.push_back('{data: 32'd0, resp: 3'd3});
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("de_no_m_valid", {m_awvalid, m_wvalid, m_arvalid}, 6'b0);
    expect_b("de");
    expect_r("de");
    tick();
    check("de_err_count", err_count, 2);
    check("de_wr_count", wr_count, 1);
    check("de_rd_count", rd_count, 1);

    // concurrent read from port 0 and write to port 1
    do_reset();
    s_araddr = 8'h08; s_arvalid = 1;
    s_awaddr = 8'h18; s_awvalid = 1; s_wdata = 32'h1234; s_wstrb = 4'h3; s_wvalid = 1;
    s_bready = 1; s_rready = 1;
    m_arready = 2'b01; m_awready = 2'b10; m_wready = 2'b10;
    exp_r_q.push_back('{data: 32'd49, resp: 3'd0});
    exp_b_q.push_back(3'd0);
    tick();
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    check("cc_arvalid", m_arvalid, 2'b01);
    check("cc_awvalid", m_awvalid, 2'b10);
    check("cc_araddr", m_araddr[7:0], 8'h08);
    tick();
    check("cc_rready", m_rready, 2'b01);
    check("cc_bready", m_bready, 2'b10);
    m_rvalid = 2'b01; m_rdata = {32'hDEAD0000, 32'd49}; m_rresp = '0;
    m_bvalid = 2'b10; m_bresp = '0;
    tick();
    m_rvalid = 0; m_bvalid = 0;
    expect_r("cc");
    expect_b("cc");
    tick();
    check("cc_rd_count", rd_count, 1);
    check("cc_wr_count", wr_count, 1);
    check("cc_err_count", err_count, 0);

    // upstream B backpressure with SLVERR, then reset during a read
    do_reset();
    s_awaddr = 8'h04; s_awvalid = 1; s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
    s_bready = 0; m_awready = 2'b01; m_wready = 2'b01;
    exp_b_q.push_back(3'd2);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    m_bvalid = 2'b01; m_bresp = {3'd0, 3'd2};
    tick();
    m_bvalid = 0; m_bresp = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_hold", s_bvalid, 1);
      check("bp_bresp_hold", s_bresp, 3'd2);
      tick();
    end
    check("bp_m_bready_low", m_bready, 0);
    s_bready = 1;
    expect_b("bp");
    tick();
    s_bready = 0;
    check("bp_wr_count", wr_count, 1);
    check("bp_err_count", err_count, 1);
    s_araddr = 8'h04; s_arvalid = 1; m_arready = 0;
    tick();
    s_arvalid = 0;
    check("mr_arvalid", m_arvalid, 2'b01);
    tick();
    check("mr_arvalid_held", m_arvalid, 2'b01);
    rst_n = 0;
    #1;
    check("mr_rst_arvalid", m_arvalid, 0);
    check("mr_rst_arready", s_arready, 0);
    check("mr_rst_rvalid", s_rvalid, 0);
    check("mr_rst_wr_count", wr_count, 0);
    check("mr_rst_err_count", err_count, 0);
    tick();
    rst_n = 1;
    #1;
    check("mr_rel_arready", s_arready, 1);
    check("mr_rel_awready", s_awready, 1);
    tick();
    check("mr_no_resp", s_rvalid, 0);
    check("sb_b_empty", exp_b_q.size(), 0);
    check("sb_r_empty", exp_r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
